game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/snake_pkg.sv | 34 +++
 rtl/step_timer.sv | 29 ++
 rtl/game_sequencer.sv | 121 ++++++++++++
 tb/tb_game_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared game state type, default tick constants and step period helper
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int unsigned DEF_TICK_BASE        = 8000000;
    localparam int unsigned DEF_TICK_DEC         = 500000;
    localparam int unsigned DEF_TICK_MIN         = 1000000;
    localparam int unsigned DEF_APPLES_PER_LEVEL = 4;
    localparam logic [3:0]  LEVEL_MAX            = 4'd15;

    // Clamp is decided before subtracting so the period can never wrap below zero.
    function automatic logic [31:0] step_period(
        input logic [3:0]  lvl,
        input logic [31:0] base,
        input logic [31:0] dec,
        input logic [31:0] min_period
    );
        logic [31:0] sub;
        sub = 32'(lvl) * dec;
        if (sub >= base)
            return min_period;
        else if ((base - sub) < min_period)
            return min_period;
        else
            return base - sub;
    endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step period down-counter with reload and one-cycle step pulse
module step_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        load,
    input  logic [31:0] period,
    output logic        step
);

    logic [31:0] count;

    assign step = run && (count == 32'd0);

    // The count is only touched while running, so a paused game resumes from where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (load) begin
            count <= period - 32'd1;
        end else if (run) begin
            if (count == 32'd0)
                count <= period - 32'd1;
            else
                count <= count - 32'd1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game state machine, level tracking and step pacing (GAME_SPEEDUP_EN)
module game_sequencer
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE        = DEF_TICK_BASE,
    parameter int unsigned TICK_DEC         = DEF_TICK_DEC,
    parameter int unsigned TICK_MIN         = DEF_TICK_MIN,
    parameter int unsigned APPLES_PER_LEVEL = DEF_APPLES_PER_LEVEL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    input  logic        apple_eaten,
    output logic        step,
    output logic        clear,
    output game_state_t state,
    output logic [3:0]  level,
    output logic        game_over
);

    localparam logic [31:0] BASE = TICK_BASE;

    logic        start_game;
    logic        run;
    logic        timer_step;
    logic [31:0] timer_period;

    assign start_game = start && ((state == ST_IDLE) || (state == ST_OVER));
    // A collision pre-empts the step of the cycle it arrives in.
    assign run        = (state == ST_PLAY) && !collision;
    assign step       = timer_step && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            clear     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            clear <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_PLAY;
                        clear <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (collision) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else if (pause) begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pause)
                        state <= ST_PLAY;
                end
                ST_OVER: begin
                    if (start) begin
                        state     <= ST_PLAY;
                        clear     <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAME_SPEEDUP_EN
    localparam int AW = $clog2(APPLES_PER_LEVEL + 1);
    localparam logic [31:0] DEC = TICK_DEC;
    localparam logic [31:0] MIN = TICK_MIN;

    logic [AW-1:0] apple_cnt;

    // A restart loads the level-0 period because the level is being zeroed on the same edge.
    assign timer_period = start_game ? step_period(4'd0, BASE, DEC, MIN)
                                     : step_period(level, BASE, DEC, MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 4'd0;
            apple_cnt <= '0;
        end else if (start_game) begin
            level     <= 4'd0;
            apple_cnt <= '0;
        end else if ((state == ST_PLAY) && apple_eaten) begin
            if (apple_cnt == AW'(APPLES_PER_LEVEL - 1)) begin
                apple_cnt <= '0;
                if (level != LEVEL_MAX)
                    level <= level + 4'd1;
            end else begin
                apple_cnt <= apple_cnt + AW'(1);
            end
        end
    end
`else
    logic unused_cfg;

    assign level        = 4'd0;
    assign timer_period = BASE;
    assign unused_cfg   = ^{apple_eaten, TICK_DEC, TICK_MIN, APPLES_PER_LEVEL};
`endif

    step_timer u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .load   (start_game),
        .period (timer_period),
        .step   (timer_step)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized and directed bench for game_sequencer against a behavioural model
module tb_game_sequencer;

    localparam int TB  = 8;
    localparam int TD  = 2;
    localparam int TM  = 2;
    localparam int APL = 2;
`ifdef GAME_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, collision = 1'b0, apple_eaten = 1'b0;
    logic       step, clear, game_over;
    logic [1:0] state;
    logic [3:0] level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .TICK_BASE        (TB),
        .TICK_DEC         (TD),
        .TICK_MIN         (TM),
        .APPLES_PER_LEVEL (APL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .collision   (collision),
        .apple_eaten (apple_eaten),
        .step        (step),
        .clear       (clear),
        .state       (state),
        .level       (level),
        .game_over   (game_over)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period_for(input int lvl);
        int p;
        if (!SPEEDUP) return TB;
        p = TB - lvl * TD;
        return (p < TM) ? TM : p;
    endfunction

    // Model: steps happen at absolute PLAY-cycle indices; each step schedules the next one a period later.
    int m_state = 0, m_level = 0, m_apples = 0, m_play_idx = 0, m_next_step = 0;
    bit m_clear = 1'b0;
    bit exp_step;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_level = 0; m_apples = 0; m_play_idx = 0; m_next_step = 0; m_clear = 1'b0;
            chk("rst_step", step, 0);
            chk("rst_clear", clear, 0);
            chk("rst_state", state, 0);
            chk("rst_level", level, 0);
            chk("rst_game_over", game_over, 0);
        end else begin
            exp_step = (m_state == 1) && !collision && !m_clear && (m_play_idx == m_next_step);
            chk("step", step, exp_step);
            chk("clear", clear, m_clear);
            chk("state", state, m_state);
            chk("level", level, m_level);
            chk("game_over", game_over, m_state == 3);
            case (m_state)
                0: if (start) begin
                    m_state = 1; m_clear = 1'b1; m_play_idx = 1; m_next_step = period_for(0);
                end
                1: begin
                    m_clear = 1'b0;
                    if (exp_step) m_next_step = m_play_idx + period_for(m_level);
                    m_play_idx++;
                    if (apple_eaten && SPEEDUP) begin
                        m_apples++;
                        if (m_apples == APL) begin
                            m_apples = 0;
                            if (m_level < 15) m_level++;
                        end
                    end
                    if (collision) m_state = 3;
                    else if (pause) m_state = 2;
                end
                2: if (pause) m_state = 1;
                default: if (start) begin
                    m_state = 1; m_clear = 1'b1; m_level = 0; m_apples = 0;
                    m_play_idx = 1; m_next_step = period_for(0);
                end
            endcase
        end
    end

    logic       obs_step, obs_clear, obs_go;
    logic [1:0] obs_state;
    logic [3:0] obs_level;

    task automatic tick(input logic s, input logic p, input logic c, input logic a);
        start = s; pause = p; collision = c; apple_eaten = a;
        @(negedge clk);
        obs_step = step; obs_clear = clear; obs_state = state; obs_level = level; obs_go = game_over;
        @(posedge clk);
        #1;
    endtask

    task automatic measure_gap(output int g);
        int n;
        g = -1;
        for (n = 0; n < 40; n++) begin
            tick(0, 0, 0, 0);
            if (obs_step) break;
        end
        if (n == 40) return;
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 0, 0);
            if (obs_step) begin
                g = k;
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int step_cycles[$];
    int clear_cycles[$];
    int gap, nsteps, idx;
    int exp_steps[3];

    initial begin
        exp_steps[0] = 8; exp_steps[1] = 16; exp_steps[2] = 24;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        tick(0, 0, 0, 0);
        chk("idle_state", obs_state, 0);

        tick(1, 0, 0, 0);
        for (int c = 1; c <= 24; c++) begin
            tick(0, 0, 0, 0);
            if (obs_step) step_cycles.push_back(c);
            if (obs_clear) clear_cycles.push_back(c);
        end
        chk("clear_count", clear_cycles.size(), 1);
        if (clear_cycles.size() > 0) chk("clear_cycle", clear_cycles[0], 1);
        chk("step_count", step_cycles.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < step_cycles.size()) chk("step_cycle", step_cycles[i], exp_steps[i]);
        chk("play_state", obs_state, 1);

        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(1, 0, 1, 1);
        chk("pause_state", obs_state, 2);
        for (int i = 0; i < 19; i++) tick(0, 0, 0, 0);
        chk("pause_level", obs_level, 0);
        tick(0, 1, 0, 0);
        gap = -1;
        for (int n = 1; n <= 20; n++) begin
            tick(0, 0, 0, 0);
            if (obs_step) begin
                gap = n;
                break;
            end
        end
        chk("resume_gap", gap, 5);

        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("start_in_play_clear", obs_clear, 0);

        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("level_after_4", obs_level, SPEEDUP ? 2 : 0);
        measure_gap(gap);
        chk("period_level2", gap, SPEEDUP ? 4 : 8);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("level_after_14", obs_level, SPEEDUP ? 7 : 0);
        measure_gap(gap);
        chk("period_clamped", gap, SPEEDUP ? 2 : 8);

        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        chk("over_state", obs_state, 3);
        chk("over_flag", obs_go, 1);
        nsteps = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, (i % 5) == 0, 1'b0, 1'b0);
            if (obs_step) nsteps++;
        end
        chk("over_no_step", nsteps, 0);
        chk("over_pause_ignored", obs_state, 3);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("restart_clear", obs_clear, 1);
        chk("restart_level", obs_level, 0);
        chk("restart_state", obs_state, 1);

        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
        start = 0; pause = 0; collision = 0; apple_eaten = 0;
        for (idx = 0; idx < 40; idx++) begin
            #1;
            if (step === 1'b1) break;
            @(posedge clk);
            #1;
        end
        chk("found_step_for_reset", idx < 40, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_step", step, 0);
        chk("async_rst_clear", clear, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_game_over", game_over, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        chk("post_rst_no_step", obs_step, 0);
        tick(1, 0, 0, 0);
        step_cycles.delete();
        for (int c = 1; c <= 8; c++) begin
            tick(0, 0, 0, 0);
            if (obs_step) step_cycles.push_back(c);
        end
        chk("post_rst_first_step", step_cycles.size() > 0 ? step_cycles[0] : -1, 8);

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12);
            if (i == 1500) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
